// File: rtl/byte_join_stream.sv
// Packs a byte stream into BYTES-wide words with valid/ready on both sides.
// Optional partial-word flush is enabled by defining BYTE_JOIN_FLUSH_EN.
module byte_join_stream #(
    parameter int unsigned BYTES = 2,
    parameter int unsigned CW    = $clog2(BYTES + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               msb_first,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*BYTES-1:0] out_data,
    output logic [CW-1:0]      out_len
);

    typedef enum logic [0:0] {StFill, StHold} state_e;

    state_e             state;
    logic [CW-1:0]      cnt;
    logic               order;
    logic [8*BYTES-1:0] data;

    logic               take;
    logic               give;
    logic               last;
    logic               wr_msb;
    logic [CW-1:0]      slot;
    logic [8*BYTES-1:0] merged;

`ifndef BYTE_JOIN_FLUSH_EN
    logic unused_flush;
    assign unused_flush = flush;
`endif

    always_comb begin
        in_ready = (state == StFill) || out_ready;
        take     = in_valid && in_ready;
        give     = out_valid && out_ready;
        last     = (cnt == CW'(BYTES - 1));
        // The first byte of a word uses the live order input; later bytes use the latched one.
        wr_msb   = (cnt == '0) ? msb_first : order;
        slot     = wr_msb ? (CW'(BYTES - 1) - cnt) : cnt;
        merged   = (state == StFill) ? data : '0;
        merged[{slot, 3'b000} +: 8] = in_data;
    end

    assign out_data = data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StFill;
            cnt       <= '0;
            order     <= 1'b0;
            data      <= '0;
            out_valid <= 1'b0;
            out_len   <= '0;
        end else begin
            unique case (state)
                StFill: begin
                    if (take) begin
                        data <= merged;
                        if (cnt == '0) begin
                            order <= msb_first;
                        end
                    end
                    if (take && last) begin
                        state     <= StHold;
                        cnt       <= '0;
                        out_valid <= 1'b1;
                        out_len   <= CW'(BYTES);
`ifdef BYTE_JOIN_FLUSH_EN
                    end else if (flush && (take || (cnt != '0))) begin
                        state     <= StHold;
                        cnt       <= '0;
                        out_valid <= 1'b1;
                        out_len   <= cnt + CW'(take);
`endif
                    end else if (take) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StHold: begin
                    if (give) begin
                        state     <= StFill;
                        out_valid <= 1'b0;
                        out_len   <= '0;
                        if (take) begin
                            // Back-to-back: this byte opens the next word with no bubble.
                            data  <= merged;
                            cnt   <= CW'(1);
                            order <= msb_first;
                        end else begin
                            data <= '0;
                            cnt  <= '0;
                        end
                    end
                end
                default: state <= StFill;
            endcase
        end
    end

endmodule

// File: doc/byte_join_stream.md
BYTE_JOIN_STREAM -- requirements
Module: byte_join_stream

Interface
REQ-001 Parameter BYTES, default 2: bytes per assembled word; legal range 2..8.
REQ-002 Parameter CW, default $clog2(BYTES+1): width of out_len.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 msb_first  input  1  byte order; 0 places the first byte lowest, 1 places it highest.
REQ-006 in_valid  input  1  in_data holds a byte.
REQ-007 in_ready  output  1  block accepts a byte this cycle.
REQ-008 in_data  input  8  byte payload.
REQ-009 flush  input  1  emit the partial word (active only with BYTE_JOIN_FLUSH_EN).
REQ-010 out_valid  output  1  out_data/out_len hold a word.
REQ-011 out_ready  input  1  consumer accepts the word.
REQ-012 out_data  output  8*BYTES  assembled word.
REQ-013 out_len  output  CW  count of valid bytes in out_data; BYTES for a full word.

Function
REQ-014 A byte transfers when in_valid && in_ready at a rising edge. A word transfers when out_valid && out_ready at a rising edge.
REQ-015 The block has two states: FILL (collecting bytes, out_valid=0) and HOLD (word presented, out_valid=1).
REQ-016 Counter cnt (0..BYTES-1) counts the bytes accepted in the current word.
REQ-017 Byte order is latched from msb_first when the first byte of a word (cnt=0) is accepted; changes mid-word have no effect on that word.
REQ-018 LSB-first: the byte with index k goes to out_data[8k+7:8k]. MSB-first: it goes to slot BYTES-1-k.
REQ-019 FILL: in_ready=1. Accepting byte index BYTES-1 moves the block to HOLD on the next cycle with out_len=BYTES and cnt=0.
REQ-020 HOLD: out_data, out_len and out_valid stay stable until the word transfers; in_ready=out_ready.
REQ-021 HOLD with a word transfer and no byte transfer: go to FILL, clear the data register to 0.
REQ-022 HOLD with a word transfer and a byte transfer in the same cycle: the byte becomes index 0 of the next word, msb_first is latched, state becomes FILL with cnt=1. No bubble results.
REQ-023 Latency: the last byte accepted at edge N gives out_valid=1 after edge N. Sustained throughput is one byte per cycle.
REQ-024 Unfilled byte slots read 0.
REQ-025 For BYTES=2 with msb_first=0, out_data = {second byte, first byte}.

Reset
REQ-026 While reset is high at a rising edge: state=FILL, cnt=0, data register=0, latched order=0, out_valid=0, out_len=0. Inputs are ignored during that cycle.
REQ-027 Reset mid-word or during HOLD discards the partial or pending word without emitting it. in_ready=1 on the first cycle after reset deasserts.

Configuration
REQ-028 Macro BYTE_JOIN_FLUSH_EN. When defined: flush in FILL with cnt>0 (counting a byte accepted in the same cycle) moves the block to HOLD. out_len equals the bytes held, and the empty slots are 0.
REQ-029 With the macro defined, these flush cases also apply:
- flush in FILL with cnt=0 and no byte accepted is ignored;
- flush in HOLD is ignored;
- a byte accepted in the same cycle as flush that completes the word gives the normal full word (out_len=BYTES).
REQ-030 When the macro is undefined, the flush port exists but is ignored, out_len is always BYTES when valid, and no flush logic is synthesised.

Verification
REQ-031 BYTES=2, msb_first=0, bytes 0x34 then 0x12, out_ready=1 -> out_data=0x1234, out_len=2, out_valid for 1 cycle, one cycle after the second byte.
REQ-032 BYTES=4, msb_first=1, bytes 0xDE,0xAD,0xBE,0xEF -> out_data=0xDEADBEEF. msb_first toggled after the first byte -> result unchanged.
REQ-033 BYTES=2, out_ready=0 held for 5 cycles after word 0xBBAA, in_valid=1 -> in_ready=0 and out_data stable. Then out_ready=1 with byte 0xCC -> 0xBBAA transfers, the next word starts with cnt=1, and 0xDDCC follows after byte 0xDD.
REQ-034 Continuous stream of 8 bytes 0x01..0x08, BYTES=2, out_ready=1 -> words 0x0201, 0x0403, 0x0605, 0x0807, no in_ready deassertion.
REQ-035 BYTE_JOIN_FLUSH_EN, BYTES=4, LSB-first, bytes 0x11,0x22 then flush -> out_data=0x00002211, out_len=2. Flush with cnt=0 -> no output.
REQ-036 Reset asserted after 1 of 2 bytes, then bytes 0x55,0x66 -> only 0x6655 is emitted. The discarded byte never appears.
